// File: rtl/des_key_pkg.sv
// Shared constants, FSM encoding and half-rotation helpers for the DES round key scheduler.
// Bit n of a key half is FIPS bit n, so a FIPS left rotate moves bits toward index 1.
package des_key_pkg;

  localparam int HALF_WIDTH   = 28;
  localparam int SUBKEY_WIDTH = 48;
  localparam int CD_WIDTH     = 2 * HALF_WIDTH;

  typedef logic [HALF_WIDTH:1] half_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_WAIT = 2'd2
  } key_state_e;

  // PC-2: subkey bit k is taken from CD bit PC2[k], with CD[56:1] = {D, C}.
  localparam logic [5:0] PC2 [1:SUBKEY_WIDTH] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  // Shift schedule: rounds 1, 2, 9 and 16 rotate by one position, all others by two.
  function automatic logic shift_is_two(input logic [4:0] round);
    case (round)
      5'd1, 5'd2, 5'd9, 5'd16: shift_is_two = 1'b0;
      default:                 shift_is_two = 1'b1;
    endcase
  endfunction

  function automatic half_t rotl(input half_t h, input logic two);
    rotl = two ? {h[2:1], h[HALF_WIDTH:3]} : {h[1], h[HALF_WIDTH:2]};
  endfunction

  function automatic half_t rotr(input half_t h, input logic two);
    rotr = two ? {h[HALF_WIDTH-2:1], h[HALF_WIDTH:HALF_WIDTH-1]}
               : {h[HALF_WIDTH-1:1], h[HALF_WIDTH]};
  endfunction

endpackage

// File: rtl/des_pc2_permute.sv
// Purely combinational DES PC-2 selection: 56-bit {D, C} in, 48-bit subkey out.
module des_pc2_permute
  import des_key_pkg::*;
(
  input  logic [CD_WIDTH:1]     cd_i,
  output logic [SUBKEY_WIDTH:1] key_o
);

  for (genvar k = 1; k <= SUBKEY_WIDTH; k++) begin : g_bit
    assign key_o[k] = cd_i[PC2[k]];
  end

endmodule

// File: rtl/des_round_key_scheduler.sv
// Produces the 16 DES round subkeys one per valid/ready handshake, in encrypt or decrypt order.
// ROUND_KEY/ROUND_NUMBER are stable while ROUND_KEY_VALID=1; a key moves on the first edge with ROUND_KEY_ACCEPT=1.
module des_round_key_scheduler #(
  parameter int NUM_ROUNDS         = 16,
  parameter int HALF_WIDTH         = 28,
  parameter int ZERO_KEY_WHEN_IDLE = 1
) (
  input  logic                  CLK,
  input  logic                  RESET_BAR,
  input  logic                  START,
  input  logic                  DECRYPT,
  input  logic [HALF_WIDTH:1]   LEFT_CIRCULAR_SHIFT1,
  input  logic [HALF_WIDTH:1]   RIGHT_CIRCULAR_SHIFT1,
  output logic [48:1]           ROUND_KEY,
  output logic                  ROUND_KEY_VALID,
  input  logic                  ROUND_KEY_ACCEPT,
  output logic [4:1]            ROUND_NUMBER,
  output logic                  BUSY,
  output logic                  DONE
);

  des_key_pkg::key_state_e state_q;
  des_key_pkg::half_t      c_q, d_q;
  des_key_pkg::half_t      c_step_d, d_step_d, c_load_d, d_load_d;
  logic                    dec_q;
  logic [4:0]              round_q, round_inc_d, round_rev_d;
  logic                    step_two_d;
  logic [48:1]             key_q, pc2_key_d;
  logic                    valid_q, done_q;
  logic [4:1]              rnum_q, rnum_d;

  des_pc2_permute u_pc2 (
    .cd_i  ({d_q, c_q}),
    .key_o (pc2_key_d)
  );

  // Decrypt walks the encrypt rotations backwards, so after presenting round r it undoes S(17-r).
  always_comb begin
    round_inc_d = round_q + 5'd1;
    round_rev_d = 5'd17 - round_q;
    step_two_d  = dec_q ? des_key_pkg::shift_is_two(round_rev_d)
                        : des_key_pkg::shift_is_two(round_inc_d);
    c_step_d    = dec_q ? des_key_pkg::rotr(c_q, step_two_d) : des_key_pkg::rotl(c_q, step_two_d);
    d_step_d    = dec_q ? des_key_pkg::rotr(d_q, step_two_d) : des_key_pkg::rotl(d_q, step_two_d);
    c_load_d    = DECRYPT ? RIGHT_CIRCULAR_SHIFT1 : des_key_pkg::rotl(RIGHT_CIRCULAR_SHIFT1, 1'b0);
    d_load_d    = DECRYPT ? LEFT_CIRCULAR_SHIFT1  : des_key_pkg::rotl(LEFT_CIRCULAR_SHIFT1, 1'b0);
    // Round 16 does not fit the 4-bit port and is presented as 4'b0000.
    rnum_d      = dec_q ? round_rev_d[3:0] : round_q[3:0];
  end

  always_ff @(posedge CLK or negedge RESET_BAR) begin
    if (!RESET_BAR) begin
      state_q <= des_key_pkg::ST_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      dec_q   <= 1'b0;
      round_q <= '0;
      key_q   <= '0;
      valid_q <= 1'b0;
      rnum_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        des_key_pkg::ST_IDLE: begin
          if (START) begin
            dec_q   <= DECRYPT;
            c_q     <= c_load_d;
            d_q     <= d_load_d;
            round_q <= 5'd1;
            state_q <= des_key_pkg::ST_EMIT;
          end
        end
        des_key_pkg::ST_EMIT: begin
          key_q   <= pc2_key_d;
          valid_q <= 1'b1;
          rnum_q  <= rnum_d;
          state_q <= des_key_pkg::ST_WAIT;
        end
        des_key_pkg::ST_WAIT: begin
          if (ROUND_KEY_ACCEPT) begin
            valid_q <= 1'b0;
            if (ZERO_KEY_WHEN_IDLE != 0) key_q <= '0;
            if (round_q == 5'(NUM_ROUNDS)) begin
              done_q  <= 1'b1;
              state_q <= des_key_pkg::ST_IDLE;
            end else begin
              round_q <= round_inc_d;
              c_q     <= c_step_d;
              d_q     <= d_step_d;
              state_q <= des_key_pkg::ST_EMIT;
            end
          end
        end
        default: state_q <= des_key_pkg::ST_IDLE;
      endcase
    end
  end

  assign ROUND_KEY       = key_q;
  assign ROUND_KEY_VALID = valid_q;
  assign ROUND_NUMBER    = rnum_q;
  assign BUSY            = (state_q != des_key_pkg::ST_IDLE);
  assign DONE            = done_q;

endmodule

// File: tb/tb_des_round_key_scheduler.sv
// Self-checking bench for des_round_key_scheduler: bit-level FIPS key schedule model feeding a
// scoreboard queue, compared against keys the DUT hands over on accepted handshakes.
module tb_des_round_key_scheduler;

  logic        CLK = 1'b0;
  logic        RESET_BAR = 1'b0;
  logic        START = 1'b0;
  logic        DECRYPT = 1'b0;
  logic [28:1] LEFT_CIRCULAR_SHIFT1 = '0;
  logic [28:1] RIGHT_CIRCULAR_SHIFT1 = '0;
  logic [48:1] ROUND_KEY;
  logic        ROUND_KEY_VALID;
  logic        ROUND_KEY_ACCEPT = 1'b0;
  logic [4:1]  ROUND_NUMBER;
  logic        BUSY;
  logic        DONE;

  des_round_key_scheduler dut (
    .CLK                   (CLK),
    .RESET_BAR             (RESET_BAR),
    .START                 (START),
    .DECRYPT               (DECRYPT),
    .LEFT_CIRCULAR_SHIFT1  (LEFT_CIRCULAR_SHIFT1),
    .RIGHT_CIRCULAR_SHIFT1 (RIGHT_CIRCULAR_SHIFT1),
    .ROUND_KEY             (ROUND_KEY),
    .ROUND_KEY_VALID       (ROUND_KEY_VALID),
    .ROUND_KEY_ACCEPT      (ROUND_KEY_ACCEPT),
    .ROUND_NUMBER          (ROUND_NUMBER),
    .BUSY                  (BUSY),
    .DONE                  (DONE)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference data ----------------
  int pc2_tbl [1:48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                         23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                         41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                         44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  int shift_tbl [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  int n_checks = 0;
  int n_fail   = 0;

  logic [48:1] exp_key_q[$];
  logic [4:1]  exp_rn_q[$];
  logic [48:1] obs_key_q[$];
  logic [4:1]  obs_rn_q[$];
  bit          valid_hist[$];
  bit          drain_timeout;
  int          done_idx;
  int          done_total = 0;
  int          start_total = 0;
  logic [48:1] done_key;
  logic [48:1] enc_keys [0:15];
  logic [28:1] c0_fips, d0_fips;

  // Hex strings read FIPS bit 1 first, i.e. bit 1 is the most significant hex digit bit.
  function automatic logic [48:1] hex_to_key(input logic [47:0] h);
    logic [48:1] r;
    for (int k = 1; k <= 48; k++) r[k] = h[48-k];
    return r;
  endfunction

  function automatic logic [28:1] hex_to_half(input logic [27:0] h);
    logic [28:1] r;
    for (int n = 1; n <= 28; n++) r[n] = h[28-n];
    return r;
  endfunction

  // FIPS schedule: rotate C/D left S(r) single places, then select with PC-2.
  task automatic push_expected(input logic [28:1] c0, input logic [28:1] d0, input bit dec);
    logic [28:1] c, d, tc, td;
    logic [48:1] ks [1:16];
    int p;
    c = c0;
    d = d0;
    for (int r = 1; r <= 16; r++) begin
      for (int s = 0; s < shift_tbl[r]; s++) begin
        tc = c;
        td = d;
        for (int n = 1; n <= 28; n++) begin
          c[n] = tc[(n % 28) + 1];
          d[n] = td[(n % 28) + 1];
        end
      end
      for (int k = 1; k <= 48; k++) begin
        p = pc2_tbl[k];
        ks[r][k] = (p <= 28) ? c[p] : d[p-28];
      end
    end
    for (int i = 1; i <= 16; i++) begin
      int r;
      r = dec ? (17 - i) : i;
      exp_key_q.push_back(ks[r]);
      exp_rn_q.push_back(4'(r));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [28:1] c0, input logic [28:1] d0, input bit dec, input bit hold);
    @(negedge CLK);
    RIGHT_CIRCULAR_SHIFT1 = c0;
    LEFT_CIRCULAR_SHIFT1  = d0;
    DECRYPT = dec;
    START   = 1'b1;
    start_total++;
    @(posedge CLK);
    #1;
    if (!hold) START = 1'b0;
  endtask

  // Runs one schedule to DONE, recording accepted keys; accept_pct sets the ACCEPT duty.
  task automatic drain(input int accept_pct, input int max_cycles);
    int cyc;
    bit acc, got_done;
    obs_key_q.delete();
    obs_rn_q.delete();
    valid_hist.delete();
    got_done = 1'b0;
    done_idx = -1;
    cyc = 0;
    while (!got_done && cyc < max_cycles) begin
      @(negedge CLK);
      valid_hist.push_back(ROUND_KEY_VALID);
      if (DONE) begin
        got_done = 1'b1;
        done_total++;
        done_idx = cyc;
        done_key = ROUND_KEY;
        ROUND_KEY_ACCEPT = 1'b0;
      end else begin
        acc = ($urandom_range(99) < 32'(accept_pct));
        ROUND_KEY_ACCEPT = acc;
        if (ROUND_KEY_VALID && acc) begin
          obs_key_q.push_back(ROUND_KEY);
          obs_rn_q.push_back(ROUND_NUMBER);
        end
      end
      cyc++;
    end
    ROUND_KEY_ACCEPT = 1'b0;
    drain_timeout = !got_done;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [31:0] r32a, r32b;
    RESET_BAR = 1'b0;
    #1;
    n_checks++;
    if ({ROUND_KEY, ROUND_KEY_VALID, ROUND_NUMBER, BUSY, DONE} !== '0) begin
      n_fail++;
      $display("FAIL reset_initial: outputs key=%h v=%b rn=%0d busy=%b done=%b, required all 0",
               ROUND_KEY, ROUND_KEY_VALID, ROUND_NUMBER, BUSY, DONE);
    end
    repeat (2) @(negedge CLK);
    RESET_BAR = 1'b1;
    r32a = $urandom();
    r32b = $urandom();
    do_start(r32a[27:0], r32b[27:0], 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    n_checks++;
    if (ROUND_KEY_VALID !== 1'b1 || BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prewait: valid=%b busy=%b, required 1 1", ROUND_KEY_VALID, BUSY);
    end
    RESET_BAR = 1'b0;
    #1;
    n_checks++;
    if ({ROUND_KEY, ROUND_KEY_VALID, ROUND_NUMBER, BUSY, DONE} !== '0) begin
      n_fail++;
      $display("FAIL reset_midwait: outputs key=%h v=%b rn=%0d busy=%b done=%b, required all 0",
               ROUND_KEY, ROUND_KEY_VALID, ROUND_NUMBER, BUSY, DONE);
    end
    @(negedge CLK);
    RESET_BAR = 1'b1;
    ROUND_KEY_ACCEPT = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      n_checks++;
      if (ROUND_KEY_VALID !== 1'b0 || BUSY !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_abort: cycle %0d valid=%b busy=%b, required 0 0", i, ROUND_KEY_VALID, BUSY);
      end
    end
    ROUND_KEY_ACCEPT = 1'b0;
    exp_key_q.delete();
    exp_rn_q.delete();
    r32a = $urandom();
    r32b = $urandom();
    push_expected(r32a[27:0], r32b[27:0], 1'b0);
    do_start(r32a[27:0], r32b[27:0], 1'b0, 1'b0);
    drain(100, 100);
    n_checks++;
    if (drain_timeout || obs_key_q.size() != 16) begin
      n_fail++;
      $display("FAIL reset_restart_count: timeout=%b keys=%0d, required 0 16", drain_timeout, obs_key_q.size());
    end
    for (int i = 0; i < obs_key_q.size() && exp_key_q.size() > 0; i++) begin
      logic [48:1] ek;
      ek = exp_key_q.pop_front();
      void'(exp_rn_q.pop_front());
      n_checks++;
      if (obs_key_q[i] !== ek) begin
        n_fail++;
        $display("FAIL reset_restart_key%0d: got %h, required %h", i, obs_key_q[i], ek);
      end
    end
  endtask

  task automatic test_encrypt;
    int fv;
    exp_key_q.delete();
    exp_rn_q.delete();
    push_expected(c0_fips, d0_fips, 1'b0);
    do_start(c0_fips, d0_fips, 1'b0, 1'b0);
    drain(100, 100);
    n_checks++;
    if (drain_timeout || obs_key_q.size() != 16) begin
      n_fail++;
      $display("FAIL enc_count: timeout=%b keys=%0d, required 0 16", drain_timeout, obs_key_q.size());
    end
    for (int i = 0; i < obs_key_q.size() && exp_key_q.size() > 0; i++) begin
      logic [48:1] ek;
      logic [4:1]  er;
      ek = exp_key_q.pop_front();
      er = exp_rn_q.pop_front();
      enc_keys[i] = ek;
      n_checks++;
      if (obs_key_q[i] !== ek || obs_rn_q[i] !== er) begin
        n_fail++;
        $display("FAIL enc_key%0d: got %h rn %0d, required %h rn %0d", i, obs_key_q[i], obs_rn_q[i], ek, er);
      end
    end
    if (obs_key_q.size() == 16) begin
      n_checks++;
      if (obs_key_q[0] !== hex_to_key(48'h1B02EFFC7072)) begin
        n_fail++;
        $display("FAIL enc_k1_fips: got %h, required %h", obs_key_q[0], hex_to_key(48'h1B02EFFC7072));
      end
      n_checks++;
      if (obs_key_q[15] !== hex_to_key(48'hCB3D8B0E17F5)) begin
        n_fail++;
        $display("FAIL enc_k16_fips: got %h, required %h", obs_key_q[15], hex_to_key(48'hCB3D8B0E17F5));
      end
    end
    fv = 0;
    while (fv < valid_hist.size() && !valid_hist[fv]) fv++;
    n_checks++;
    if (fv > 2) begin
      n_fail++;
      $display("FAIL enc_latency: first valid at sample %0d, required at most 2", fv);
    end
    for (int i = fv; i <= fv + 30 && i < valid_hist.size(); i++) begin
      n_checks++;
      if (valid_hist[i] !== ((i - fv) % 2 == 0)) begin
        n_fail++;
        $display("FAIL enc_valid_pattern: sample %0d valid=%b, required %b", i, valid_hist[i], ((i - fv) % 2 == 0));
      end
    end
    n_checks++;
    if (done_idx !== fv + 31) begin
      n_fail++;
      $display("FAIL enc_done_timing: done at sample %0d, required %0d", done_idx, fv + 31);
    end
    n_checks++;
    if (done_key !== '0) begin
      n_fail++;
      $display("FAIL enc_idle_key: key %h while idle, required 0", done_key);
    end
  endtask

  task automatic test_decrypt;
    exp_key_q.delete();
    exp_rn_q.delete();
    push_expected(c0_fips, d0_fips, 1'b1);
    do_start(c0_fips, d0_fips, 1'b1, 1'b0);
    drain(100, 100);
    n_checks++;
    if (drain_timeout || obs_key_q.size() != 16) begin
      n_fail++;
      $display("FAIL dec_count: timeout=%b keys=%0d, required 0 16", drain_timeout, obs_key_q.size());
    end
    for (int i = 0; i < obs_key_q.size() && exp_key_q.size() > 0; i++) begin
      logic [48:1] ek;
      logic [4:1]  er;
      ek = exp_key_q.pop_front();
      er = exp_rn_q.pop_front();
      n_checks++;
      if (obs_key_q[i] !== ek || obs_rn_q[i] !== er || obs_key_q[i] !== enc_keys[15-i]) begin
        n_fail++;
        $display("FAIL dec_key%0d: got %h rn %0d, required %h rn %0d", i, obs_key_q[i], obs_rn_q[i], ek, er);
      end
    end
    if (obs_key_q.size() == 16) begin
      // Round 16 reads back as 0 on the 4-bit ROUND_NUMBER port.
      n_checks++;
      if (obs_key_q[0] !== hex_to_key(48'hCB3D8B0E17F5) || obs_rn_q[0] !== 4'd0) begin
        n_fail++;
        $display("FAIL dec_first: got %h rn %0d, required %h rn 0", obs_key_q[0], obs_rn_q[0], hex_to_key(48'hCB3D8B0E17F5));
      end
      n_checks++;
      if (obs_key_q[15] !== hex_to_key(48'h1B02EFFC7072) || obs_rn_q[15] !== 4'd1) begin
        n_fail++;
        $display("FAIL dec_last: got %h rn %0d, required %h rn 1", obs_key_q[15], obs_rn_q[15], hex_to_key(48'h1B02EFFC7072));
      end
    end
  endtask

  task automatic test_backpressure;
    int hold, cyc;
    bit got_done;
    logic [48:1] snap_key;
    logic [4:1]  snap_rn;
    exp_key_q.delete();
    exp_rn_q.delete();
    push_expected(c0_fips, d0_fips, 1'b0);
    do_start(c0_fips, d0_fips, 1'b0, 1'b0);
    hold = 0;
    cyc = 0;
    got_done = 1'b0;
    snap_key = '0;
    snap_rn = '0;
    while (!got_done && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      if (DONE) begin
        got_done = 1'b1;
      end else if (ROUND_KEY_VALID && ROUND_NUMBER == 4'd3 && hold < 5) begin
        if (hold == 0) begin
          snap_key = ROUND_KEY;
          snap_rn  = ROUND_NUMBER;
        end else begin
          n_checks++;
          if (ROUND_KEY !== snap_key || ROUND_NUMBER !== snap_rn) begin
            n_fail++;
            $display("FAIL bp_stable: hold %0d key %h rn %0d, required %h rn %0d", hold, ROUND_KEY, ROUND_NUMBER, snap_key, snap_rn);
          end
        end
        hold++;
        ROUND_KEY_ACCEPT = 1'b0;
      end else begin
        ROUND_KEY_ACCEPT = 1'b1;
        if (ROUND_KEY_VALID) begin
          logic [48:1] ek;
          logic [4:1]  er;
          ek = (exp_key_q.size() > 0) ? exp_key_q.pop_front() : 'x;
          er = (exp_rn_q.size() > 0) ? exp_rn_q.pop_front() : 'x;
          n_checks++;
          if (ROUND_KEY !== ek || ROUND_NUMBER !== er) begin
            n_fail++;
            $display("FAIL bp_key: got %h rn %0d, required %h rn %0d", ROUND_KEY, ROUND_NUMBER, ek, er);
          end
        end
      end
    end
    ROUND_KEY_ACCEPT = 1'b0;
    n_checks++;
    if (!got_done || hold != 5 || exp_key_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_end: done=%b hold=%0d left=%0d, required 1 5 0", got_done, hold, exp_key_q.size());
    end
  endtask

  task automatic test_start_held;
    do_start(c0_fips, d0_fips, 1'b0, 1'b1);
    RIGHT_CIRCULAR_SHIFT1 = 'z;
    LEFT_CIRCULAR_SHIFT1  = 'z;
    drain(100, 100);
    n_checks++;
    if (drain_timeout || obs_key_q.size() != 16) begin
      n_fail++;
      $display("FAIL held_count: timeout=%b keys=%0d, required 0 16", drain_timeout, obs_key_q.size());
    end
    for (int i = 0; i < obs_key_q.size() && i < 16; i++) begin
      n_checks++;
      if (obs_key_q[i] !== enc_keys[i]) begin
        n_fail++;
        $display("FAIL held_key%0d: got %h, required %h", i, obs_key_q[i], enc_keys[i]);
      end
    end
    RIGHT_CIRCULAR_SHIFT1 = c0_fips;
    LEFT_CIRCULAR_SHIFT1  = d0_fips;
    @(posedge CLK);
    #1;
    start_total++;
    START = 1'b0;
    n_checks++;
    if (BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL held_restart: busy=%b after done, required 1", BUSY);
    end
    drain(100, 100);
    n_checks++;
    if (drain_timeout || obs_key_q.size() != 16 || obs_key_q[0] !== enc_keys[0] || obs_key_q[15] !== enc_keys[15]) begin
      n_fail++;
      $display("FAIL held_second: timeout=%b keys=%0d, required 0 16 with encrypt sequence", drain_timeout, obs_key_q.size());
    end
  endtask

  task automatic test_random;
    logic [31:0] r32a, r32b;
    bit dec;
    int done_before, start_before;
    done_before = done_total;
    start_before = start_total;
    for (int it = 0; it < 200; it++) begin
      r32a = $urandom();
      r32b = $urandom();
      dec  = 1'($urandom_range(1));
      exp_key_q.delete();
      exp_rn_q.delete();
      push_expected(r32a[27:0], r32b[27:0], dec);
      do_start(r32a[27:0], r32b[27:0], dec, 1'b0);
      drain(60, 400);
      n_checks++;
      if (drain_timeout || obs_key_q.size() != 16) begin
        n_fail++;
        $display("FAIL rand%0d_count: timeout=%b keys=%0d, required 0 16", it, drain_timeout, obs_key_q.size());
      end
      for (int i = 0; i < obs_key_q.size() && exp_key_q.size() > 0; i++) begin
        logic [48:1] ek;
        logic [4:1]  er;
        ek = exp_key_q.pop_front();
        er = exp_rn_q.pop_front();
        n_checks++;
        if (obs_key_q[i] !== ek || obs_rn_q[i] !== er) begin
          n_fail++;
          $display("FAIL rand%0d_key%0d: got %h rn %0d, required %h rn %0d", it, i, obs_key_q[i], obs_rn_q[i], ek, er);
        end
      end
    end
    n_checks++;
    if (done_total - done_before != start_total - start_before) begin
      n_fail++;
      $display("FAIL rand_done_count: done %0d, required %0d", done_total - done_before, start_total - start_before);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    c0_fips = hex_to_half(28'hF0CCAAF);
    d0_fips = hex_to_half(28'h556678F);
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_start_held();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
